regfile_reader: RTL

Read-side sequencer for the processor's 16-entry register file. On a start pulse it sweeps both read ports: port A at index i, port B at (i + OFFSET) mod 16. Each captured pair is presented on a valid/ready output stream together with a running modular sum of port-A data. It sits between the register file read ports and a debug/dump consumer, and is the reading counterpart to the register-load sequence.

---
 rtl/regfile_reader_pkg.sv | 18 +
 rtl/RegisterFile.sv | 33 +++
 rtl/regfile_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/regfile_reader_pkg.sv
// Shared definitions for the register-file read sequencer.
//   - Default widths matching the 16-entry register file: data N, address A,
//     port-B address offset OFFSET.
//   - 2-bit FSM state encoding used by regfile_reader.
package regfile_reader_pkg;

    localparam int unsigned DefN      = 16;
    localparam int unsigned DefA      = 4;
    localparam int unsigned DefOffset = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StHold = 2'd2,
        StDone = 2'd3
    } state_t;

endpackage

// File: rtl/RegisterFile.sv
// Register file with one synchronous write port and two combinational read
// ports, each read port gated by its enable (reads as zero when disabled).
//   clk                 : write clock
//   we, waddr, wdata    : write port
//   ra_addr/ra_en/ra_data, rb_addr/rb_en/rb_data : read ports A and B
module RegisterFile #(
    parameter int unsigned N = 16,
    parameter int unsigned A = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [N-1:0] wdata,
    input  logic [A-1:0] ra_addr,
    input  logic         ra_en,
    output logic [N-1:0] ra_data,
    input  logic [A-1:0] rb_addr,
    input  logic         rb_en,
    output logic [N-1:0] rb_data
);

    logic [N-1:0] mem [2**A];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = ra_en ? mem[ra_addr] : '0;
    assign rb_data = rb_en ? mem[rb_addr] : '0;

endmodule

// File: rtl/regfile_reader.sv
// Read-side sequencer for the register file. A start pulse sweeps all 2^A
// entries: port A reads index i, port B reads (i + OFFSET) mod 2^A. Each
// captured pair is offered on a valid/ready stream with a running N-bit
// wrap-around sum of port-A data.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a sweep (only honoured in idle)
//   ra_addr/rb_addr     : read addresses (registered, hold when not reading)
//   ra_en/rb_en         : read enables, high only in the read state
//   ra_data/rb_data     : combinational read data from the register file
//   out_a/out_b/out_idx : captured pair and its port-A index
//   out_valid/out_ready : output handshake
//   sum                 : running sum of captured port-A data
//   busy                : sweep in progress (read or hold)
//   done                : one-cycle pulse at sweep completion
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int unsigned N      = DefN,
    parameter int unsigned A      = DefA,
    parameter int unsigned OFFSET = DefOffset
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [A-1:0] ra_addr,
    output logic [A-1:0] rb_addr,
    output logic         ra_en,
    output logic         rb_en,
    input  logic [N-1:0] ra_data,
    input  logic [N-1:0] rb_data,
    output logic [N-1:0] out_a,
    output logic [N-1:0] out_b,
    output logic [A-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         busy,
    output logic         done
);

    // Truncation to A bits is the mod 2^A of the offset.
    localparam logic [A-1:0] OffsetA = A'(OFFSET);
    localparam logic [A-1:0] LastIdx = {A{1'b1}};

    state_t       state_q, state_d;
    logic [A-1:0] idx_q, idx_d;
    logic [A-1:0] ra_addr_q, ra_addr_d;
    logic [A-1:0] rb_addr_q, rb_addr_d;
    logic [N-1:0] out_a_q, out_a_d;
    logic [N-1:0] out_b_q, out_b_d;
    logic [A-1:0] out_idx_q, out_idx_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] sum_q, sum_d;
    logic [A-1:0] idx_inc;

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ra_addr_d   = ra_addr_q;
        rb_addr_d   = rb_addr_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRead;
                    idx_d     = '0;
                    sum_d     = '0;
                    // Addresses are loaded on entry to the read state so they
                    // come straight from flops during the read cycle.
                    ra_addr_d = '0;
                    rb_addr_d = OffsetA;
                end
            end
            StRead: begin
                out_a_d     = ra_data;
                out_b_d     = rb_data;
                out_idx_d   = idx_q;
                sum_d       = sum_q + ra_data;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d     = idx_inc;
                        ra_addr_d = idx_inc;
                        rb_addr_d = idx_inc + OffsetA;
                        state_d   = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            ra_addr_q   <= '0;
            rb_addr_q   <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ra_addr_q   <= ra_addr_d;
            rb_addr_q   <= rb_addr_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
        end
    end

    // Enables and status come only from the state flop, so they cannot glitch.
    assign ra_en     = (state_q == StRead);
    assign rb_en     = (state_q == StRead);
    assign busy      = (state_q == StRead) || (state_q == StHold);
    assign done      = (state_q == StDone);
    assign ra_addr   = ra_addr_q;
    assign rb_addr   = rb_addr_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;

endmodule
